// File: rtl/calc_pkg.sv
// Types and constants shared by the calculator and the blocks that sit in front of it.
package calc_pkg;

    localparam int DW    = 3;
    localparam int OPW   = 2;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    // Opcodes understood by the calculator's control unit.
    localparam logic [OPW-1:0] OP_ADD = 2'd0;
    localparam logic [OPW-1:0] OP_SUB = 2'd1;
    localparam logic [OPW-1:0] OP_XOR = 2'd2;
    localparam logic [OPW-1:0] OP_AND = 2'd3;

endpackage

// File: rtl/calc_share_arb_if.sv
// Calculator-side bus: start pulse and latched operands out, completion and result back.
interface calc_share_arb_if
    import calc_pkg::*;
#(
    parameter int DW  = calc_pkg::DW,
    parameter int OPW = calc_pkg::OPW
);

    logic           calc_go;
    logic [OPW-1:0] calc_op;
    logic [DW-1:0]  calc_in1;
    logic [DW-1:0]  calc_in2;
    logic           calc_done;
    logic [DW-1:0]  calc_out;

    modport master (
        output calc_go, calc_op, calc_in1, calc_in2,
        input  calc_done, calc_out
    );

    modport slave (
        input  calc_go, calc_op, calc_in1, calc_in2,
        output calc_done, calc_out
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the client not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       any
);

    always_comb begin
        any    = |req;
        gnt_id = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/calc_share_arb.sv
// Shares one calculator between two clients: grant, issue one go, wait for done
// (or watchdog abort), then return the result with a one-cycle ack.
module calc_share_arb
    import calc_pkg::*;
#(
    parameter int DW      = calc_pkg::DW,
    parameter int OPW     = calc_pkg::OPW,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0,
    input  logic           req1,
    input  logic [OPW-1:0] op0,
    input  logic [OPW-1:0] op1,
    input  logic [DW-1:0]  a0,
    input  logic [DW-1:0]  a1,
    input  logic [DW-1:0]  b0,
    input  logic [DW-1:0]  b1,
    output logic           ack0,
    output logic           ack1,
    output logic [DW-1:0]  result,
    output logic           err,
    calc_share_arb_if.master calc
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state;
    logic             gnt_q;
    logic             last_q;
    logic             err_q;
    logic [DW-1:0]    res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pick_id;
    logic             pick_any;

    rr_arb2 u_rr_arb2 (
        .req    ({req1, req0}),
        .last   (last_q),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_q        <= 1'b1;
            gnt_q         <= 1'b0;
            err_q         <= 1'b0;
            res_q         <= '0;
            cnt_q         <= '0;
            calc.calc_go  <= 1'b0;
            calc.calc_op  <= '0;
            calc.calc_in1 <= '0;
            calc.calc_in2 <= '0;
        end else begin
            calc.calc_go <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_q         <= pick_id;
                        calc.calc_op  <= pick_id ? op1 : op0;
                        calc.calc_in1 <= pick_id ? a1 : a0;
                        calc.calc_in2 <= pick_id ? b1 : b0;
                        calc.calc_go  <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                    state <= WAIT;
                end
                // A done arriving on the watchdog's last cycle still counts as success.
                WAIT: begin
                    if (calc.calc_done) begin
                        res_q <= calc.calc_out;
                        err_q <= 1'b0;
                        state <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    last_q <= gnt_q;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response outputs are decoded from registers only, so they change only at the edge.
    assign ack0   = (state == RESP) && !gnt_q;
    assign ack1   = (state == RESP) && gnt_q;
    assign result = (state == RESP) ? res_q : '0;
    assign err    = (state == RESP) && err_q;

endmodule
